// File: rtl/stack_controller.sv
// Multi-cycle control unit for a stack-machine datapath: a Moore FSM that
// sequences fetch, decode, stack pops/pushes, ALU ops, memory moves and jumps.
module stack_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    output logic       LorD,
    output logic       read,
    output logic       write,
    output logic       StackSrc,
    output logic       tos,
    output logic       push,
    output logic       pop,
    output logic       RegDst,
    output logic       LA,
    output logic       LB,
    output logic       Ain,
    output logic       Bin,
    output logic [1:0] ALUop,
    output logic       next,
    output logic       jump,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IF    = 4'd0,
        ID    = 4'd1,
        POPA  = 4'd2,
        POPB  = 4'd3,
        ALU   = 4'd4,
        WB    = 4'd5,
        PUSHM = 4'd6,
        POPM  = 4'd7,
        STORE = 4'd8,
        JUMP  = 4'd9,
        BR    = 4'd10
    } stateT;

    logic [3:0] stateReg;
    logic [3:0] stateNext;
    // ALU operation latched while opcode is still valid, so the ALU state
    // drives ALUop from a register rather than from the live input.
    logic [1:0] aluSel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IF;
            aluSel   <= 2'b00;
        end else begin
            stateReg <= stateNext;
            if (stateReg == ID || stateReg == POPA)
                aluSel <= opcode[1:0];
        end
    end

    always_comb begin
        stateNext = IF;
        case (stateReg)
            IF: stateNext = ID;
            ID: begin
                case (opcode)
                    3'b100:  stateNext = PUSHM;
                    3'b101:  stateNext = POPM;
                    3'b110:  stateNext = JUMP;
                    default: stateNext = POPA;
                endcase
            end
            POPA: begin
                case (opcode)
                    3'b000, 3'b001, 3'b010: stateNext = POPB;
                    3'b011:                 stateNext = ALU;
                    3'b111:                 stateNext = BR;
                    default:                stateNext = IF;
                endcase
            end
            POPB:    stateNext = ALU;
            ALU:     stateNext = WB;
            POPM:    stateNext = STORE;
            default: stateNext = IF;
        endcase
    end

    always_comb begin
        LorD       = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        StackSrc   = 1'b0;
        tos        = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        RegDst     = 1'b0;
        LA         = 1'b0;
        LB         = 1'b0;
        Ain        = 1'b0;
        Bin        = 1'b0;
        ALUop      = 2'b00;
        next       = 1'b0;
        jump       = 1'b0;
        instr_done = 1'b0;
        // Reset also masks the IF strobes, so nothing reaches memory or stack.
        if (!rst) begin
            case (stateReg)
                IF: begin
                    read = 1'b1;
                    Ain  = 1'b1;
                    Bin  = 1'b1;
                    next = 1'b1;
                end
                ID: tos = 1'b1;
                POPA, POPM: begin
                    pop    = 1'b1;
                    RegDst = 1'b1;
                    LA     = 1'b1;
                end
                POPB: begin
                    pop = 1'b1;
                    LB  = 1'b1;
                end
                ALU: begin
                    StackSrc = 1'b1;
                    Ain      = 1'b1;
                    Bin      = 1'b1;
                    ALUop    = aluSel;
                end
                WB: begin
                    push       = 1'b1;
                    StackSrc   = 1'b1;
                    instr_done = 1'b1;
                end
                PUSHM: begin
                    read       = 1'b1;
                    LorD       = 1'b1;
                    push       = 1'b1;
                    instr_done = 1'b1;
                end
                STORE: begin
                    write      = 1'b1;
                    LorD       = 1'b1;
                    instr_done = 1'b1;
                end
                JUMP, BR: begin
                    jump       = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = stateReg;

endmodule

// File: tb/tb_stack_controller.sv
// Scoreboard bench for stack_controller: stimulus queues the expected
// per-cycle state/output trace, a negedge monitor pops and compares it.
module tb_stack_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       LorD, read, write, StackSrc, tos, push, pop, RegDst;
    logic       LA, LB, Ain, Bin, next, jump, instr_done;
    logic [1:0] ALUop;
    logic [3:0] state;
    logic [16:0] act;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    stack_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .LorD(LorD), .read(read), .write(write), .StackSrc(StackSrc),
        .tos(tos), .push(push), .pop(pop), .RegDst(RegDst),
        .LA(LA), .LB(LB), .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
        .next(next), .jump(jump), .instr_done(instr_done), .state(state)
    );

    assign act = {LorD, read, write, StackSrc, tos, push, pop, RegDst,
                  LA, LB, Ain, Bin, ALUop, next, jump, instr_done};

    localparam int B_LORD = 16, B_READ = 15, B_WRITE = 14, B_SSRC = 13;
    localparam int B_TOS = 12, B_PUSH = 11, B_POP = 10, B_RDST = 9;
    localparam int B_LA = 8, B_LB = 7, B_AIN = 6, B_BIN = 5, B_OP = 3;
    localparam int B_NEXT = 2, B_JUMP = 1, B_DONE = 0;

    localparam logic [16:0] O_NONE  = 17'd0;
    localparam logic [16:0] O_IF    = 17'((1 << B_READ) | (1 << B_AIN) | (1 << B_BIN) | (1 << B_NEXT));
    localparam logic [16:0] O_ID    = 17'(1 << B_TOS);
    localparam logic [16:0] O_POPA  = 17'((1 << B_POP) | (1 << B_RDST) | (1 << B_LA));
    localparam logic [16:0] O_POPB  = 17'((1 << B_POP) | (1 << B_LB));
    localparam logic [16:0] O_ALU   = 17'((1 << B_SSRC) | (1 << B_AIN) | (1 << B_BIN));
    localparam logic [16:0] O_WB    = 17'((1 << B_PUSH) | (1 << B_SSRC) | (1 << B_DONE));
    localparam logic [16:0] O_PUSHM = 17'((1 << B_READ) | (1 << B_LORD) | (1 << B_PUSH) | (1 << B_DONE));
    localparam logic [16:0] O_STORE = 17'((1 << B_WRITE) | (1 << B_LORD) | (1 << B_DONE));
    localparam logic [16:0] O_JMP   = 17'((1 << B_JUMP) | (1 << B_DONE));

    typedef struct {
        logic [3:0]  st;
        logic [16:0] o;
    } expT;

    expT q[$];
    int  cyc = 0;

    task automatic ex(input logic [3:0] s, input logic [16:0] o);
        expT e;
        e.st = s;
        e.o  = o;
        q.push_back(e);
    endtask

    function automatic logic [16:0] aluOut(input logic [1:0] op);
        return O_ALU | (17'(op) << B_OP);
    endfunction

    // Wait at posedges until at most n trace entries remain, then step off the edge.
    task automatic waitLeft(input int n);
        for (int i = 0; i < 40 && q.size() > n; i++) @(posedge clk);
        if (q.size() > n) begin
            nTests++;
            nFail++;
            $display("FAIL timeout: %0d entries left, want %0d", q.size(), n);
            q.delete();
        end
        #1;
    endtask

    always @(negedge clk) begin
        expT e;
        cyc++;
        nTests++;
        if ((read && write) || (push && pop)) begin
            nFail++;
            $display("FAIL exclusive cyc=%0d read=%b write=%b push=%b pop=%b, want no overlap",
                     cyc, read, write, push, pop);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            nTests++;
            if (state !== e.st || act !== e.o) begin
                nFail++;
                $display("FAIL trace cyc=%0d state=%0d outs=%b, want state=%0d outs=%b",
                         cyc, state, act, e.st, e.o);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        opcode = 3'b000;
        // Held in reset: IF state but every output masked.
        ex(4'd0, O_NONE);
        ex(4'd0, O_NONE);
        waitLeft(0);
        rst = 1'b0;

        // ADD; opcode changed after POPB must not alter ALUop.
        opcode = 3'b000;
        ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd2, O_POPA); ex(4'd3, O_POPB);
        ex(4'd4, aluOut(2'b00)); ex(4'd5, O_WB);
        waitLeft(2);
        opcode = 3'b110;
        waitLeft(0);

        // SUB and AND
        for (int op = 1; op <= 2; op++) begin
            opcode = 3'(op);
            ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd2, O_POPA); ex(4'd3, O_POPB);
            ex(4'd4, aluOut(2'(op))); ex(4'd5, O_WB);
            waitLeft(0);
        end

        // NOT: single pop, straight to ALU
        opcode = 3'b011;
        ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd2, O_POPA);
        ex(4'd4, aluOut(2'b11)); ex(4'd5, O_WB);
        waitLeft(0);

        // PUSH then POP back to back
        opcode = 3'b100;
        ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd6, O_PUSHM);
        waitLeft(0);
        opcode = 3'b101;
        ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd7, O_POPA); ex(4'd8, O_STORE);
        waitLeft(0);

        // JZ then JMP
        opcode = 3'b111;
        ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd2, O_POPA); ex(4'd10, O_JMP);
        waitLeft(0);
        opcode = 3'b110;
        ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd9, O_JMP);
        waitLeft(0);

        // Asynchronous reset in the middle of POPB
        opcode = 3'b000;
        ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd2, O_POPA); ex(4'd3, O_POPB);
        waitLeft(1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        nTests++;
        if (state !== 4'd0 || act !== O_NONE) begin
            nFail++;
            $display("FAIL asyncRst state=%0d outs=%b, want state=0 outs=%b", state, act, O_NONE);
        end
        ex(4'd0, O_NONE);
        waitLeft(0);
        rst = 1'b0;
        ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd2, O_POPA); ex(4'd3, O_POPB);
        ex(4'd4, aluOut(2'b00)); ex(4'd5, O_WB);
        waitLeft(0);

        // Illegal state code recovers to IF with outputs dark
        opcode = 3'b110;
        force dut.stateReg = 4'd13;
        #1;
        release dut.stateReg;
        ex(4'd13, O_NONE); ex(4'd0, O_IF); ex(4'd1, O_ID); ex(4'd9, O_JMP);
        waitLeft(0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  3  instruction class from the datapath (IR[7:5]).
REQ-005 LorD  out  1  memory address select: 0 = PC, 1 = IR[4:0].
REQ-006 read, write  out  1 each  memory read and write strobes.
REQ-007 StackSrc  out  1  stack data select: 0 = memory data, 1 = ALU result; 0 also selects PC/constant 1 at ALU inputs.
REQ-008 tos, push, pop  out  1 each  stack top-read, push and pop strobes.
REQ-009 RegDst  out  1  popped value destination: 1 = A, 0 = B.
REQ-010 LA, LB  out  1 each  load enables for regA and regB.
REQ-011 Ain, Bin  out  1 each  ALU operand source enables.
REQ-012 ALUop  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 NOT.
REQ-013 next, jump  out  1 each  PC-update request: sequential or jump (jump is conditional on regA==0 for JZ, resolved in the datapath).
REQ-014 instr_done  out  1  one-cycle pulse on the last cycle of every instruction.
REQ-015 state  out  4  current state encoding, for debug.

Function
REQ-016 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
REQ-017 Moore FSM; outputs are a function of the state register only; every output not listed for a state is 0.
REQ-018 State encodings: IF=0, ID=1, POPA=2, POPB=3, ALU=4, WB=5, PUSHM=6, POPM=7, STORE=8, JUMP=9, BR=10; codes 11-15 are illegal.
REQ-019 IF: read=1, LorD=0, Ain=1, Bin=1, ALUop=00, next=1 (PC+1); next state ID.
REQ-020 ID: tos=1; next state by opcode: 000-011 and 111 -> POPA, 100 -> PUSHM, 101 -> POPM, 110 -> JUMP.
REQ-021 POPA: pop=1, RegDst=1, LA=1; next state: 000-010 -> POPB, 011 -> ALU, 111 -> BR.
REQ-022 POPB: pop=1, RegDst=0, LB=1; next state ALU.
REQ-023 ALU: StackSrc=1, Ain=1, Bin=1, ALUop=opcode[1:0]; next state WB.
REQ-024 WB: push=1, StackSrc=1, instr_done=1; next state IF.
REQ-025 PUSHM: read=1, LorD=1, push=1, StackSrc=0, instr_done=1; next state IF.
REQ-026 POPM: pop=1, RegDst=1, LA=1; next state STORE.
REQ-027 STORE: write=1, LorD=1, instr_done=1; next state IF.
REQ-028 JUMP and BR: jump=1, instr_done=1; next state IF.
REQ-029 Latency in cycles, IF through last state inclusive: ADD/SUB/AND 6, NOT 5, PUSH 3, POP 4, JMP 3, JZ 4.
REQ-030 opcode is sampled only in ID and POPA; changes in any other state have no effect.
REQ-031 read and write are never asserted in the same cycle; push and pop are never asserted in the same cycle.
REQ-032 An illegal state code transitions to IF on the next edge with all outputs 0.

Reset
REQ-033 rst high forces state=IF asynchronously, with no clock edge required.
REQ-034 All outputs are 0 while rst is high, including the IF outputs.
REQ-035 The first IF cycle, with its outputs asserted, occurs in the first clock period after rst deasserts.
REQ-036 rst asserted mid-instruction aborts the instruction immediately; no further push, pop or write strobes are issued for it.

Verification
REQ-037 Reset, then opcode=000 held -> states 0,1,2,3,4,5,0; ALUop=00 in ALU; push=1 and instr_done=1 only in WB.
REQ-038 opcode=011 (NOT) -> states 0,1,2,4,5; exactly one pop pulse; ALUop=11 in ALU.
REQ-039 opcode=100 then 101 -> PUSHM shows read=1, push=1, LorD=1; POPM then STORE shows write=1, LorD=1; instr_done at cycles 3 and 7.
REQ-040 opcode=111 -> states 0,1,2,10; jump=1 only in BR; opcode=110 -> states 0,1,9 with jump=1.
REQ-041 Assert rst asynchronously in POPB -> state=0 and all outputs 0 before the next edge; after release, IF outputs read=1, next=1.
REQ-042 Force state=13 -> next edge state=0; all cycles checked for read&write=0 and push&pop=0.
